dmem_responder: RTL and testbench

- Data-memory responder: the memory end of the data request/response handshake that the MEM/WB stage drives.
- Accepts one read or write per transaction and holds it for a programmable latency.
- Returns a one-cycle mem_resp pulse, with registered read data for reads.
- Backs the pipeline in simulation and small FPGA builds; lc3b word-addressed storage is internal.

---
 rtl/lc3b_types.sv | 13 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 92 +++++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared lc3b types for the data-memory responder: word and byte-mask widths, FSM states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// 2^ADDR_BITS x 16 synchronous storage with per-byte write enable and a registered read port.
module dmem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  lc3b_word             wdata,
    input  lc3b_mem_wmask        wmask,
    input  logic                 re,
    output lc3b_word             rdata
);

    lc3b_word mem [2**ADDR_BITS];

    // Storage is never cleared by reset, so it lives in its own reset-free block.
    always_ff @(posedge clk) begin
        if (wmask[0]) mem[addr][7:0]  <= wdata[7:0];
        if (wmask[1]) mem[addr][15:8] <= wdata[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: holds each request for LATENCY wait cycles, then pulses mem_resp.
// Define DMEM_CHECK_EN to flag request signals that change while a transaction is waiting.
module dmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY   = 3,
    parameter int ADDR_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          protocol_err
);

    dmem_state_t   state;
    logic [3:0]    count;
    logic          cap_read;
    logic          cap_write;
    lc3b_word      cap_address;
    lc3b_word      cap_wdata;
    lc3b_mem_wmask cap_be;

    logic          commit;
    lc3b_mem_wmask array_wmask;
    logic          unused_addr_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            mem_resp     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        cap_read    <= mem_read;
                        cap_write   <= mem_write;
                        cap_address <= mem_address;
                        cap_wdata   <= mem_wdata;
                        cap_be      <= mem_byte_enable;
                        count       <= 4'(LATENCY - 1);
                        state       <= WAIT;
                        if (mem_read && mem_write) protocol_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
`ifdef DMEM_CHECK_EN
                    if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable} !=
                        {cap_read, cap_write, cap_address, cap_wdata, cap_be})
                        protocol_err <= 1'b1;
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The array acts on the last WAIT edge; gating with rst keeps an aborted write from landing.
    assign commit      = (state == WAIT) && (count == 4'd0) && !rst;
    assign array_wmask = (commit && cap_write) ? cap_be : 2'b00;

    // Only the word-index bits reach the array; the rest of the byte address is dropped.
    assign unused_addr_bits = ^{cap_address, cap_read};

    dmem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .addr (cap_address[ADDR_BITS:1]),
        .wdata(cap_wdata),
        .wmask(array_wmask),
        .re   (commit && !cap_write),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single transactions plus abort, conflict and stability sequences.
module tb_dmem_responder;

    localparam int LATENCY = 3;
`ifdef DMEM_CHECK_EN
    localparam logic CHK_ERR = 1'b1;
`else
    localparam logic CHK_ERR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        protocol_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    dmem_responder #(
        .LATENCY  (LATENCY),
        .ADDR_BITS(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .protocol_err   (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        mem_byte_enable = 2'b00;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drive a request in cycle 0 and watch it for a fixed window; optionally move the address in cycle 2.
    task automatic apply_stimulus(input string name, input logic rd, input logic wr,
                                  input logic [15:0] addr, input logic [15:0] wdata,
                                  input logic [1:0] be, input logic [15:0] exp_rdata,
                                  input logic exp_err, input logic bump,
                                  input logic [15:0] bump_addr);
        int resp_cycle = -1;
        int pulses = 0;
        logic [15:0] rdata_seen = 16'h0000;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        for (int k = 1; k <= LATENCY + 5; k++) begin
            @(posedge clk); #1;
            if (bump && k == 2) mem_address = bump_addr;
            if (mem_resp) begin
                pulses++;
                if (resp_cycle < 0) begin
                    resp_cycle = k;
                    rdata_seen = mem_rdata;
                end
                idle_inputs();
            end
        end
        check_output({name, " resp_cycle"}, 32'(resp_cycle), 32'(LATENCY + 1));
        check_output({name, " resp_pulses"}, 32'(pulses), 32'd1);
        check_output({name, " rdata"}, 32'(rdata_seen), 32'(exp_rdata));
        check_output({name, " protocol_err"}, 32'(protocol_err), 32'(exp_err));
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'hBEEF};
        vecs[1]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'h1234};
        vecs[2]  = '{1'b0, 1'b1, 16'h0020, 16'hAB55, 2'b01, 16'h1234};
        vecs[3]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 16'h1255};
        vecs[4]  = '{1'b0, 1'b1, 16'h0021, 16'hCD00, 2'b10, 16'h1255};
        vecs[5]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'hCD55};
        vecs[6]  = '{1'b0, 1'b1, 16'h0040, 16'h1111, 2'b11, 16'hCD55};
        vecs[7]  = '{1'b0, 1'b1, 16'h0040, 16'h2222, 2'b00, 16'hCD55};
        vecs[8]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h1111};
        vecs[9]  = '{1'b0, 1'b1, 16'h0030, 16'h0000, 2'b11, 16'h1111};
        vecs[10] = '{1'b0, 1'b1, 16'h0062, 16'h3333, 2'b11, 16'h1111};
        vecs[11] = '{1'b0, 1'b1, 16'h0060, 16'h0000, 2'b11, 16'h1111};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("reset mem_resp", 32'(mem_resp), 32'd0);
        check_output("reset mem_rdata", 32'(mem_rdata), 32'd0);
        check_output("reset protocol_err", 32'(protocol_err), 32'd0);

        // Preload, then reset: the stored word must survive the reset.
        apply_stimulus("preload", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h0);
        pulse_reset();
        apply_stimulus("read_preload", 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                           vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata, 1'b0, 1'b0, 16'h0);
        end

        // Reset in the second WAIT cycle of a write: no response and no commit.
        mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'hFFFF; mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        pulses = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        if (mem_resp) pulses++;
        for (int k = 0; k < LATENCY + 3; k++) begin
            @(posedge clk); #1;
            if (mem_resp) pulses++;
        end
        check_output("abort resp_pulses", 32'(pulses), 32'd0);
        check_output("abort rdata_cleared", 32'(mem_rdata), 32'd0);
        apply_stimulus("abort_read", 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b0, 16'h0);

        // Read and write together: performed as a write, error sticks until reset.
        apply_stimulus("both", 1'b1, 1'b1, 16'h0050, 16'h7777, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h0);
        apply_stimulus("both_read", 1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, 16'h7777, 1'b1, 1'b0, 16'h0);
        pulse_reset();
        check_output("err_cleared", 32'(protocol_err), 32'd0);

        // Address moved mid-WAIT: captured address wins, error only with the checker built in.
        apply_stimulus("bump", 1'b0, 1'b1, 16'h0060, 16'h9999, 2'b11, 16'h0000, CHK_ERR, 1'b1, 16'h0062);
        apply_stimulus("bump_read_orig", 1'b1, 1'b0, 16'h0060, 16'h0000, 2'b00, 16'h9999, CHK_ERR, 1'b0, 16'h0);
        apply_stimulus("bump_read_other", 1'b1, 1'b0, 16'h0062, 16'h0000, 2'b00, 16'h3333, CHK_ERR, 1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
